lcd_byte_sequencer: RTL and testbench
=====================================

Name: lcd_byte_sequencer

Overview:
Controller for the VC707 character LCD (HD44780-compatible, 4-bit bus). It performs the power-on initialisation sequence on its own. After that it accepts command and data bytes from a client over a valid/ready handshake. Each byte is split into two nibbles, the E strobe is generated with fixed timing, and the command-specific execution delay is enforced before the next byte is accepted. It sits between any text or status producer and the LCD pins.

Parameters:
CYCLES_PER_US, 50, clk cycles per microsecond (C below)
POWER_ON_US, 45000, power-on wait before first nibble
INIT_LONG_US, 5000, wait after first 0x3 init nibble
INIT_SHORT_US, 200, wait after 2nd/3rd 0x3 nibble and after 0x2 nibble
EXEC_US, 40, execution wait for normal bytes
LONG_EXEC_US, 1640, execution wait for clear/home commands

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  client has a byte to send
req_rs  in  1  0 = command, 1 = character data
req_data  in  8  byte to send
req_ready  out  1  sequencer can accept a byte this cycle
init_done  out  1  power-on init complete, sticky until rst
busy  out  1  transfer or wait in progress (inverse of req_ready once init_done=1)
ctrl_lcd  out  3  {RS, RW, E}; RW is always 0
data_lcd  out  4  LCD DB7..DB4

Behaviour:
- Reset (rst=1 sampled at posedge):
  - All outputs are registered 0: ctrl_lcd=000, data_lcd=0000, req_ready=0, init_done=0, busy=1 once out of reset.
  - Counter is cleared and state returns to PWR_WAIT.
  - Reset mid-transfer drops E on the next edge and discards the latched byte.
- States: PWR_WAIT, INIT_NIB, HI_E, HI_GAP, LO_E, LO_GAP, EXEC_WAIT, IDLE.
- Single 32-bit cycle counter, cleared on every state change.
- PWR_WAIT: lasts POWER_ON_US*C cycles, then moves to INIT_NIB.
- INIT_NIB, single-nibble writes with RS=0:
  - Order: 0x3 then wait INIT_LONG_US; 0x3 then wait INIT_SHORT_US; 0x3 then wait INIT_SHORT_US; 0x2 then wait INIT_SHORT_US.
  - Each nibble: E=1 for C cycles, then E=0 for C cycles with data held, then the wait (data held, E=0).
- Internal byte writes, RS=0, after the init nibbles: 0x28, 0x0C, 0x01, 0x06.
  - These use the same HI_E..EXEC_WAIT path as client bytes.
  - When the EXEC_WAIT of 0x06 completes: init_done is set and the state moves to IDLE.
- Byte path:
  - HI_E: data_lcd=byte[7:4], RS=latched rs, E=1, C cycles.
  - HI_GAP: same data, E=0, C cycles.
  - LO_E: data_lcd=byte[3:0], E=1, C cycles.
  - LO_GAP: same data, E=0, C cycles.
  - EXEC_WAIT: E=0, data held, X*C cycles.
    - X=LONG_EXEC_US if rs=0 and byte[7:2]==0 (0x01, 0x02, 0x03).
    - Otherwise X=EXEC_US.
  - After EXEC_WAIT: go to IDLE.
- IDLE:
  - req_ready=1, ctrl_lcd=000, data_lcd=0000.
  - Handshake completes when req_valid & req_ready at a posedge; req_data and req_rs are latched at that edge.
  - At that edge, req_ready falls and the state becomes HI_E.
  - E is first high in the cycle immediately after acceptance.
- Latency: byte accepted at edge N → req_ready high again after exactly 4C + X*C cycles (at edge N + 4C + X*C).
- req_ready is never asserted before init_done=1. req_valid during init is ignored and need not be held stable.
- Client must hold req_data/req_rs only while req_valid=1 and req_ready=0; values outside the accept edge are don't-care.
- All outputs are registered; no combinational path from req_* to ctrl_lcd or data_lcd.

Test Plan:
- Reset/init, with CYCLES_PER_US=2, POWER_ON_US=10, INIT_LONG_US=5, INIT_SHORT_US=3, EXEC_US=2, LONG_EXEC_US=8:
  - Sequence: 20 idle cycles; E pulses carry nibbles 3,3,3,2, then 2,8,0,C,0,1,0,6.
  - Each E pulse is 2 cycles wide; the gap after the 0x01 low nibble is 2+16 cycles.
  - init_done rises, and req_ready=1 in the same cycle.
- Data byte 'A' (rs=1, 0x41) accepted at edge N:
  - RS=1 during both pulses; data 4 then 1.
  - req_ready returns at N+12 (4*2+2*2).
- Command 0x01 (rs=0): req_ready returns at N+24 (8+16). Command 0x80: returns at N+12.
- req_valid held high continuously with bytes 0x48, 0x69:
  - Two back-to-back transfers, req_ready high for exactly one cycle between them.
  - No request is accepted before init_done.
- rst asserted during LO_E of a data byte:
  - Next cycle: ctrl_lcd=000, data_lcd=0, req_ready=0, init_done=0.
  - After release, the full init sequence replays from PWR_WAIT.
- req_valid pulsed during PWR_WAIT and INIT_NIB: no extra E pulses; the first client byte after init is the only transfer.

Source files
------------

// File: rtl/lcd_byte_sequencer.sv
// lcd_byte_sequencer: drives an HD44780-compatible character LCD over its 4-bit bus.
// Runs the power-on init sequence by itself. It then accepts command/data bytes over
// valid/ready, sends each byte as two E-strobed nibbles, and holds off the next byte
// until the LCD has had time to execute it.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   req_valid  client has a byte to send
//   req_rs     0 = command, 1 = character data
//   req_data   byte to send
//   req_ready  byte accepted on a posedge where req_valid & req_ready
//   init_done  power-on init finished (sticky until rst)
//   busy       transfer or wait in progress
//   ctrl_lcd   {RS, RW, E}, RW tied low
//   data_lcd   LCD DB7..DB4
module lcd_byte_sequencer #(
  parameter int unsigned CYCLES_PER_US = 50,
  parameter int unsigned POWER_ON_US   = 45000,
  parameter int unsigned INIT_LONG_US  = 5000,
  parameter int unsigned INIT_SHORT_US = 200,
  parameter int unsigned EXEC_US       = 40,
  parameter int unsigned LONG_EXEC_US  = 1640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic [2:0] ctrl_lcd,
  output logic [3:0] data_lcd
);

  localparam logic [31:0] Cyc          = 32'(CYCLES_PER_US);
  localparam logic [31:0] PwrCyc       = 32'(POWER_ON_US * CYCLES_PER_US);
  localparam logic [31:0] InitLongCyc  = 32'(INIT_LONG_US * CYCLES_PER_US);
  localparam logic [31:0] InitShortCyc = 32'(INIT_SHORT_US * CYCLES_PER_US);
  localparam logic [31:0] ExecCyc      = 32'(EXEC_US * CYCLES_PER_US);
  localparam logic [31:0] LongExecCyc  = 32'(LONG_EXEC_US * CYCLES_PER_US);

  typedef enum logic [2:0] {
    StPwrWait,
    StInitNib,
    StHiE,
    StHiGap,
    StLoE,
    StLoGap,
    StExecWait,
    StIdle
  } state_e;

  // Byte-mode setup issued after the raw init nibbles: function set, display on,
  // clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  nib_q, nib_d;    // which raw init nibble is being sent
  logic [1:0]  bidx_q, bidx_d;  // which init byte is being sent
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        init_done_q, init_done_d;

  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [3:0]  data_q, data_d;

  logic [31:0] phase_len;
  logic        phase_last;

  always_comb begin
    phase_len = Cyc;
    unique case (state_q)
      StPwrWait:  phase_len = PwrCyc;
      StInitNib:  phase_len = 2 * Cyc + ((nib_q == 2'd0) ? InitLongCyc : InitShortCyc);
      // Clear/home commands need the long execution time.
      StExecWait: phase_len = (!rs_q && (byte_q[7:2] == 6'd0)) ? LongExecCyc : ExecCyc;
      default:    phase_len = Cyc;
    endcase
  end

  assign phase_last = (cnt_q == phase_len - 32'd1);

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    nib_d       = nib_q;
    bidx_d      = bidx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StPwrWait: begin
        if (phase_last) begin
          state_d = StInitNib;
          cnt_d   = '0;
        end
      end
      StInitNib: begin
        if (phase_last) begin
          cnt_d = '0;
          if (nib_q == 2'd3) begin
            state_d = StHiE;
            bidx_d  = 2'd0;
            byte_d  = init_byte(2'd0);
            rs_d    = 1'b0;
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end
      end
      StHiE: begin
        if (phase_last) begin
          state_d = StHiGap;
          cnt_d   = '0;
        end
      end
      StHiGap: begin
        if (phase_last) begin
          state_d = StLoE;
          cnt_d   = '0;
        end
      end
      StLoE: begin
        if (phase_last) begin
          state_d = StLoGap;
          cnt_d   = '0;
        end
      end
      StLoGap: begin
        if (phase_last) begin
          state_d = StExecWait;
          cnt_d   = '0;
        end
      end
      StExecWait: begin
        if (phase_last) begin
          cnt_d = '0;
          if (init_done_q) begin
            state_d = StIdle;
          end else if (bidx_q == 2'd3) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end else begin
            state_d = StHiE;
            bidx_d  = bidx_q + 2'd1;
            byte_d  = init_byte(bidx_q + 2'd1);
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (req_valid && ready_q) begin
          state_d = StHiE;
          byte_d  = req_data;
          rs_d    = req_rs;
        end
      end
      default: begin
        state_d = StPwrWait;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered without
  // adding a cycle of lag relative to the state.
  always_comb begin
    ctrl_d  = 3'b000;
    data_d  = 4'h0;
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    unique case (state_d)
      StInitNib: begin
        ctrl_d = {2'b00, (cnt_d < Cyc)};
        data_d = (nib_d == 2'd3) ? 4'h2 : 4'h3;
      end
      StHiE: begin
        ctrl_d = {rs_d, 2'b01};
        data_d = byte_d[7:4];
      end
      StHiGap: begin
        ctrl_d = {rs_d, 2'b00};
        data_d = byte_d[7:4];
      end
      StLoE: begin
        ctrl_d = {rs_d, 2'b01};
        data_d = byte_d[3:0];
      end
      StLoGap, StExecWait: begin
        ctrl_d = {rs_d, 2'b00};
        data_d = byte_d[3:0];
      end
      default: begin
        ctrl_d = 3'b000;
        data_d = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPwrWait;
      cnt_q       <= '0;
      nib_q       <= 2'd0;
      bidx_q      <= 2'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      ctrl_q      <= 3'b000;
      data_q      <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nib_q       <= nib_d;
      bidx_q      <= bidx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
    end
  end

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign ctrl_lcd  = ctrl_q;
  assign data_lcd  = data_q;

endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// Directed bench for lcd_byte_sequencer with small timing parameters.
module tb_lcd_byte_sequencer;

  localparam int unsigned C = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic       busy;
  logic [2:0] ctrl_lcd;
  logic [3:0] data_lcd;

  lcd_byte_sequencer #(
    .CYCLES_PER_US(2),
    .POWER_ON_US  (10),
    .INIT_LONG_US (5),
    .INIT_SHORT_US(3),
    .EXEC_US      (2),
    .LONG_EXEC_US (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_ready(req_ready),
    .init_done(init_done),
    .busy     (busy),
    .ctrl_lcd (ctrl_lcd),
    .data_lcd (data_lcd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed E rise times (cycles after the last reset edge) and nibbles.
  localparam int unsigned InitT [12] = '{20, 34, 44, 54, 64, 68, 76, 80, 88, 92, 112, 116};
  localparam logic [3:0]  InitN [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                         4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // E pulse monitor.
  int unsigned rise_t[$];
  logic [3:0]  rise_nib[$];
  logic        rise_rs[$];
  int unsigned width_q[$];
  int unsigned last_rise = 0;
  logic        e_prev = 1'b0;
  logic        ready_early = 1'b0;

  always @(negedge clk) begin
    if (ctrl_lcd[0] && !e_prev) begin
      rise_t.push_back(cyc);
      rise_nib.push_back(data_lcd);
      rise_rs.push_back(ctrl_lcd[2]);
      last_rise <= cyc;
    end
    if (!ctrl_lcd[0] && e_prev && !rst) width_q.push_back(cyc - last_rise);
    if (req_ready && !init_done) ready_early <= 1'b1;
    e_prev <= ctrl_lcd[0];
  end

  task automatic clear_mon();
    rise_t.delete();
    rise_nib.delete();
    rise_rs.delete();
    width_q.delete();
  endtask

  int unsigned t0;

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done_time"}, cyc - t0, 124);
    check_val({tag, "_ready_with_done"}, req_ready, 1'b1);
    check_val({tag, "_busy_low"}, busy, 1'b0);
    check_val({tag, "_no_early_ready"}, ready_early, 1'b0);
    check_val({tag, "_pulse_count"}, rise_t.size(), 12);
    for (int i = 0; i < 12 && i < rise_t.size(); i++) begin
      check_val($sformatf("%s_t%0d", tag, i), rise_t[i] - t0, InitT[i]);
      check_val($sformatf("%s_nib%0d", tag, i), rise_nib[i], InitN[i]);
      check_val($sformatf("%s_rs%0d", tag, i), rise_rs[i], 1'b0);
    end
    for (int i = 0; i < width_q.size(); i++)
      check_val($sformatf("%s_width%0d", tag, i), width_q[i], C);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_val({tag, "_ready_timeout"}, req_ready, 1'b1);
  endtask

  // Sends one byte and checks the two pulses and the ready-to-ready latency.
  task automatic send_byte(input string tag, input logic rs, input logic [7:0] b,
                           input int unsigned lat);
    int unsigned acc;
    wait_ready(tag);
    clear_mon();
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = b;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = 8'hxx;
    check_val({tag, "_ready_low"}, req_ready, 1'b0);
    wait_ready(tag);
    check_val({tag, "_latency"}, cyc - acc, lat);
    check_val({tag, "_pulses"}, rise_t.size(), 2);
    if (rise_t.size() >= 2) begin
      check_val({tag, "_hi_t"}, rise_t[0] - acc, 0);
      check_val({tag, "_lo_t"}, rise_t[1] - acc, 2 * C);
      check_val({tag, "_hi_nib"}, rise_nib[0], b[7:4]);
      check_val({tag, "_lo_nib"}, rise_nib[1], b[3:0]);
      check_val({tag, "_hi_rs"}, rise_rs[0], rs);
      check_val({tag, "_lo_rs"}, rise_rs[1], rs);
    end
    for (int i = 0; i < width_q.size(); i++)
      check_val($sformatf("%s_width%0d", tag, i), width_q[i], C);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned a1, a2, rt, acc;
    int n;

    // Reset and power-on init, with stray requests during PWR_WAIT and INIT_NIB.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
    clear_mon();
    check_val("rst_ctrl", ctrl_lcd, 3'b000);
    check_val("rst_data", data_lcd, 4'h0);
    check_val("rst_ready", req_ready, 1'b0);
    check_val("rst_init_done", init_done, 1'b0);
    check_val("rst_busy", busy, 1'b1);
    repeat (5) @(negedge clk);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    while (cyc - t0 < 36) @(negedge clk);
    req_valid = 1'b1;
    req_data  = 8'hAA;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    wait_init("init");

    // Single bytes, including the long-exec boundary cases.
    send_byte("char_A", 1'b1, 8'h41, 12);
    send_byte("cmd_clear", 1'b0, 8'h01, 24);
    send_byte("cmd_ddram", 1'b0, 8'h80, 12);
    send_byte("cmd_03", 1'b0, 8'h03, 24);
    send_byte("cmd_04", 1'b0, 8'h04, 12);
    send_byte("data_01", 1'b1, 8'h01, 12);

    // Back-to-back with req_valid held high.
    wait_ready("b2b");
    clear_mon();
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h48;
    @(posedge clk);
    #1 a1 = cyc;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    rt = cyc;
    req_data = 8'h69;
    @(posedge clk);
    #1 a2 = cyc;
    @(negedge clk);
    check_val("b2b_ready_one_cycle", req_ready, 1'b0);
    req_valid = 1'b0;
    wait_ready("b2b_end");
    check_val("b2b_ready_time", rt - a1, 12);
    check_val("b2b_second_accept", a2 - a1, 13);
    check_val("b2b_pulses", rise_t.size(), 4);
    if (rise_t.size() >= 4) begin
      check_val("b2b_n0", rise_nib[0], 4'h4);
      check_val("b2b_n1", rise_nib[1], 4'h8);
      check_val("b2b_n2", rise_nib[2], 4'h6);
      check_val("b2b_n3", rise_nib[3], 4'h9);
      check_val("b2b_t2", rise_t[2] - a1, 13);
      check_val("b2b_t3", rise_t[3] - a1, 17);
    end

    // Reset during LO_E of a data byte.
    wait_ready("mid_rst");
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc - acc < 4) @(negedge clk);
    check_val("lo_e_ctrl", ctrl_lcd, 3'b101);
    check_val("lo_e_data", data_lcd, 4'hA);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_ctrl", ctrl_lcd, 3'b000);
    check_val("mid_rst_data", data_lcd, 4'h0);
    check_val("mid_rst_ready", req_ready, 1'b0);
    check_val("mid_rst_init_done", init_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
    clear_mon();
    wait_init("reinit");
    send_byte("post_reinit", 1'b1, 8'h42, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
